multicore_mem_loader: RTL and testbench
=======================================

Name: multicore_mem_loader

Overview:
- Synthesizable loader/unloader that replaces hand-sequenced bench stimulus for the multicore processor top.
- Takes commands plus a word stream and performs four jobs: writes any core's IRAM, writes shared DRAM, runs the processor, and streams back a DRAM result window.
- Sits between a host/UART front end and the top_control_N external-access ports; parametrised in core count, widths, write-enable hold and run timeout.

Parameters:
- NUM_CORES, 4, number of cores / IRAM write enables (1..8)
- ADDR_W, 9, external address width
- DATA_W, 16, instruction/data word width
- WR_HOLD, 4, cycles write enable is held per word (>=1)
- RD_LAT, 5, cycles read_en_ext is held before dram_in is sampled (>=1)
- RUN_MAX, 120000, run-phase timeout in cycles

Ports:
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  loader idle, command accepted when both high
- cmd_op  in  2  0=LOAD_IRAM, 1=LOAD_DRAM, 2=RUN, 3=READBACK
- cmd_core  in  3  target core for LOAD_IRAM
- cmd_base  in  ADDR_W  first address
- cmd_count  in  ADDR_W  number of words (0 allowed)
- in_valid / in_ready  in/out  1  input word handshake
- in_data  in  DATA_W  word to write
- out_valid / out_ready  out/in  1  readback handshake
- out_data  out  DATA_W  readback word
- addr_ext  out  ADDR_W  address to top
- data_in_ins  out  DATA_W  IRAM write data
- data_in_dram  out  DATA_W  DRAM write data
- iram_write_ext  out  NUM_CORES  one-hot IRAM write enables
- dram_write_ext  out  1  DRAM write enable
- read_en_ext  out  1  DRAM read enable
- dram_in  in  DATA_W  DRAM read data from top
- mode_ins / mode_dram / mode_read  out  1  top access-mode selects (start_2/3/4)
- start  out  1  processor run
- proc_done  in  1  processor completion
- busy  out  1  not IDLE
- err  out  1  one-cycle pulse: illegal core or run timeout
- timeout  out  1  sticky, set on RUN timeout, cleared by next accepted command
- checksum  out  DATA_W  see Optional Feature

Behaviour:
- Reset: all outputs 0, state IDLE; cmd_ready=1 one cycle after rst_n rises. Reset asserted mid-operation drops every enable/start immediately (asynchronous) and discards the job.
- IDLE: cmd_ready=1. On accept, latch op/core/base/count; addr counter=base, remaining=count. cmd_ready=0 in every other state; commands offered then are not accepted.
- LOAD_IRAM with cmd_core>=NUM_CORES: err pulse, stay IDLE, no bus activity.
- count=0 for any load/readback: return to IDLE next cycle, no enables, no in_ready/out_valid.
- LOAD flow: mode_ins (IRAM) or mode_dram (DRAM) held high for the whole job.
  - WAIT_IN: in_ready=1; on in_valid, register word onto data_in_ins/data_in_dram, go SETUP.
  - SETUP: 1 cycle, address/data stable, enables low.
  - WE: enable high exactly WR_HOLD cycles (iram_write_ext bit cmd_core, or dram_write_ext).
  - GAP: 1 cycle enables low; addr += 1 modulo 2^ADDR_W (wrap 511->0 at ADDR_W=9); remaining -= 1; then WAIT_IN, or IDLE at 0.
  - Address/data never change while any enable is high.
- RUN: start=1 from the cycle after accept.
  - Ends on proc_done=1 (start drops next cycle, IDLE) or after RUN_MAX cycles (start drops, timeout=1, err pulse, IDLE).
  - proc_done high in the accept cycle is ignored.
- READBACK: mode_read high for the whole job.
  - REN: read_en_ext high RD_LAT cycles; dram_in captured into out_data on the last one.
  - OUT: read_en_ext low, out_valid=1 held with out_data stable until out_ready; then addr += 1 (wrapping), remaining -= 1, next word or IDLE.
  - out_ready may be held low indefinitely (backpressure, no data loss).
- busy = (state != IDLE).
- Per-word LOAD cost: WR_HOLD+2 cycles after the handshake. Per-word READBACK cost: RD_LAT+1 cycles minimum.

Optional Feature:
- LOADER_CHECKSUM_EN defined: checksum = modulo-2^DATA_W sum of every word written (loads) or emitted (readback) during the current job. Cleared on command accept, updated in GAP / on the out handshake, held after the job ends.
- Undefined: checksum tied to 0, no adder logic.

Test Plan:
- LOAD_IRAM core 2, base 1, count 3, words 10,20,30 -> only iram_write_ext[2] pulses, 4 cycles each, at addr 1,2,3 with matching data_in_ins; mode_ins high throughout; checksum=60 if enabled.
- LOAD_IRAM cmd_core=5 (NUM_CORES=4) -> err one-cycle pulse, no enables, cmd_ready stays 1.
- LOAD_DRAM base 510, count 3 -> dram_write_ext at addr 510, 511, 0 (wrap).
- RUN with proc_done raised after 50 cycles -> start high 50 cycles, timeout=0; RUN with RUN_MAX=100 and no done -> start drops at cycle 100, err pulse, timeout=1.
- READBACK base 100, count 2, memory model returns 7 then 9, out_ready low for 10 cycles -> out_data 7 held stable, then 9; read_en_ext high 5 cycles per word.
- rst_n low mid-WE during a DRAM load -> dram_write_ext and mode_dram drop in the same cycle; after release busy=0, cmd_ready=1, and a new command completes normally.

Source files
------------

// File: rtl/multicore_mem_loader.sv
// Command-driven IRAM/DRAM loader, run sequencer and DRAM readback streamer.
// Optional LOADER_CHECKSUM_EN adds a per-job word sum on checksum.
module multicore_mem_loader #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int WR_HOLD   = 4,
  parameter int RD_LAT    = 5,
  parameter int RUN_MAX   = 120000
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [2:0]           cmd_core,
  input  logic [ADDR_W-1:0]    cmd_base,
  input  logic [ADDR_W-1:0]    cmd_count,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [ADDR_W-1:0]    addr_ext,
  output logic [DATA_W-1:0]    data_in_ins,
  output logic [DATA_W-1:0]    data_in_dram,
  output logic [NUM_CORES-1:0] iram_write_ext,
  output logic                 dram_write_ext,
  output logic                 read_en_ext,
  input  logic [DATA_W-1:0]    dram_in,
  output logic                 mode_ins,
  output logic                 mode_dram,
  output logic                 mode_read,
  output logic                 start,
  input  logic                 proc_done,
  output logic                 busy,
  output logic                 err,
  output logic                 timeout,
  output logic [DATA_W-1:0]    checksum
);

  localparam int M1 = (WR_HOLD > RD_LAT) ? WR_HOLD : RD_LAT;
  localparam int CMAX = (RUN_MAX > M1) ? RUN_MAX : M1;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_WE    = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_REN   = 3'd6;
  localparam logic [2:0] S_OUT   = 3'd7;

  localparam logic [1:0] OP_IRAM = 2'd0;
  localparam logic [1:0] OP_DRAM = 2'd1;
  localparam logic [1:0] OP_RUN  = 2'd2;
  localparam logic [1:0] OP_RDBK = 2'd3;

  logic [2:0]        state;
  logic [1:0]        op;
  logic [2:0]        core;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] remaining;
  logic [CW-1:0]     cnt;
  logic              alive;
  logic              accept;
  logic              core_ok;
  logic              last;
  logic              load_st;

  assign accept  = cmd_valid && cmd_ready;
  assign core_ok = {1'b0, cmd_core} < 4'(NUM_CORES);
  assign last    = remaining == ADDR_W'(1);
  assign load_st = (state == S_WAIT) || (state == S_SETUP) ||
                   (state == S_WE) || (state == S_GAP);

  assign cmd_ready = alive && (state == S_IDLE);
  assign busy      = state != S_IDLE;
  assign in_ready  = state == S_WAIT;
  assign out_valid = state == S_OUT;
  assign start     = state == S_RUN;
  assign read_en_ext = state == S_REN;
  assign mode_ins  = load_st && (op == OP_IRAM);
  assign mode_dram = load_st && (op == OP_DRAM);
  assign mode_read = (state == S_REN) || (state == S_OUT);
  assign addr_ext  = addr;
  assign dram_write_ext = (state == S_WE) && (op == OP_DRAM);
  assign iram_write_ext = ((state == S_WE) && (op == OP_IRAM)) ?
                          (NUM_CORES'(1) << core) : '0;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      op           <= OP_IRAM;
      core         <= '0;
      addr         <= '0;
      remaining    <= '0;
      cnt          <= '0;
      alive        <= 1'b0;
      err          <= 1'b0;
      timeout      <= 1'b0;
      data_in_ins  <= '0;
      data_in_dram <= '0;
      out_data     <= '0;
    end else begin
      alive <= 1'b1;
      err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            timeout <= 1'b0;
            cnt     <= '0;
            // an illegal core is rejected without touching the bus
            if (cmd_op == OP_IRAM && !core_ok) begin
              err <= 1'b1;
            end else begin
              op        <= cmd_op;
              core      <= cmd_core;
              addr      <= cmd_base;
              remaining <= cmd_count;
              unique case (1'b1)
                cmd_op == OP_RUN:
                  state <= S_RUN;
                cmd_op == OP_RDBK:
                  if (cmd_count != '0) state <= S_REN;
                default:
                  if (cmd_count != '0) state <= S_WAIT;
              endcase
            end
          end
        end
        S_WAIT: begin
          if (in_valid) begin
            if (op == OP_IRAM) data_in_ins <= in_data;
            else data_in_dram <= in_data;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          cnt   <= '0;
          state <= S_WE;
        end
        S_WE: begin
          if (cnt == CW'(WR_HOLD - 1)) state <= S_GAP;
          else cnt <= cnt + 1'b1;
        end
        S_GAP: begin
          addr      <= addr + 1'b1;
          remaining <= remaining - 1'b1;
          state     <= last ? S_IDLE : S_WAIT;
        end
        S_RUN: begin
          if (proc_done) begin
            state <= S_IDLE;
          end else if (cnt == CW'(RUN_MAX - 1)) begin
            state   <= S_IDLE;
            timeout <= 1'b1;
            err     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_REN: begin
          if (cnt == CW'(RD_LAT - 1)) begin
            out_data <= dram_in;
            state    <= S_OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
            cnt       <= '0;
            state     <= last ? S_IDLE : S_REN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  assign checksum = sum;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (accept) begin
      sum <= '0;
    end else if (state == S_GAP) begin
      sum <= sum + ((op == OP_IRAM) ? data_in_ins : data_in_dram);
    end else if (state == S_OUT && out_ready) begin
      sum <= sum + out_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_multicore_mem_loader.sv
// Randomized self-checking bench for multicore_mem_loader.
// Bus monitor rebuilds write/read transactions; model predicts them.
module tb_multicore_mem_loader;
  localparam int NC = 4;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int WH = 4;
  localparam int RL = 5;
  localparam int RM = 100;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [2:0] cmd_core = '0;
  logic [AW-1:0] cmd_base = '0;
  logic [AW-1:0] cmd_count = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] addr_ext;
  logic [DW-1:0] data_in_ins, data_in_dram;
  logic [NC-1:0] iram_write_ext;
  logic dram_write_ext, read_en_ext;
  logic [DW-1:0] dram_in;
  logic mode_ins, mode_dram, mode_read;
  logic start;
  logic proc_done = 1'b0;
  logic busy, err, timeout;
  logic [DW-1:0] checksum;

  multicore_mem_loader #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW),
    .WR_HOLD(WH), .RD_LAT(RL), .RUN_MAX(RM)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_core(cmd_core),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .addr_ext(addr_ext), .data_in_ins(data_in_ins),
    .data_in_dram(data_in_dram), .iram_write_ext(iram_write_ext),
    .dram_write_ext(dram_write_ext), .read_en_ext(read_en_ext),
    .dram_in(dram_in), .mode_ins(mode_ins), .mode_dram(mode_dram),
    .mode_read(mode_read), .start(start), .proc_done(proc_done),
    .busy(busy), .err(err), .timeout(timeout), .checksum(checksum)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NC-1:0] ien;
    logic          den;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            len;
  } wr_t;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_dram [DEPTH];
  logic [DW-1:0] words [$];
  wr_t wq [$];
  int  ren_q [$];
  wr_t cur;
  int  hold = 0;
  int  ren_len = 0;
  int  start_len = 0;
  int  err_cycles = 0;
  int  stable_bad = 0;
  int  mode_bad = 0;
  int  exp_mode = 0;
  int  compared = 0;
  int  mismatched = 0;

  assign dram_in = read_en_ext ? mem[addr_ext] : '0;

  always @(negedge clock) begin
    if ((|iram_write_ext) || dram_write_ext) begin
      if (hold == 0) begin
        cur.ien = iram_write_ext;
        cur.den = dram_write_ext;
        cur.a   = addr_ext;
        cur.d   = dram_write_ext ? data_in_dram : data_in_ins;
      end else if (cur.a != addr_ext || cur.ien != iram_write_ext ||
                   cur.den != dram_write_ext ||
                   cur.d != (dram_write_ext ? data_in_dram : data_in_ins)) begin
        stable_bad++;
      end
      hold++;
    end else if (hold > 0) begin
      cur.len = hold;
      wq.push_back(cur);
      if (cur.den && hold == WH) mem[cur.a] = cur.d;
      hold = 0;
    end
    if (read_en_ext) ren_len++;
    else if (ren_len > 0) begin
      ren_q.push_back(ren_len);
      ren_len = 0;
    end
    if (start) start_len++;
    if (err) err_cycles++;
    if (busy) begin
      if (mode_ins != (exp_mode == 1) || mode_dram != (exp_mode == 2) ||
          mode_read != (exp_mode == 3))
        mode_bad++;
    end else if (mode_ins || mode_dram || mode_read || start || in_ready ||
                 out_valid || read_en_ext || dram_write_ext ||
                 (|iram_write_ext)) begin
      mode_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] core,
                       input logic [AW-1:0] base, input logic [AW-1:0] cnt);
    int n;
    sync();
    cmd_op = op; cmd_core = core; cmd_base = base; cmd_count = cnt;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 1000) begin
      sync();
      n++;
    end
    if (n >= 1000) check("cmd_wait", 0, 1);
    sync();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      sync();
      n++;
    end
    if (n >= 3000) check("idle_wait", 0, 1);
  endtask

  task automatic do_load(input logic [1:0] op, input logic [2:0] core,
                         input logic [AW-1:0] base);
    int n;
    logic [DW-1:0] sum;
    logic [AW-1:0] a;
    logic [NC-1:0] ien;
    wq.delete();
    exp_mode = (op == 2'd0) ? 1 : 2;
    issue(op, core, base, AW'(words.size()));
    sum = '0;
    foreach (words[i]) begin
      repeat ($urandom_range(0, 3)) sync();
      in_data = words[i];
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
        sync();
        n++;
      end
      if (n >= 100) check("in_wait", 0, 1);
      sync();
      in_valid = 1'b0;
      in_data = DW'($urandom);
    end
    wait_idle();
    check("wr_cnt", wq.size(), words.size());
    ien = (op == 2'd0) ? (NC'(1) << core) : '0;
    foreach (words[i]) begin
      a = base + AW'(i);
      sum = sum + words[i];
      if (op == 2'd1) ref_dram[a] = words[i];
      if (i < wq.size()) begin
        check("wr_en", {wq[i].den, wq[i].ien}, {op == 2'd1, ien});
        check("wr_addr", wq[i].a, a);
        check("wr_data", wq[i].d, words[i]);
        check("wr_len", wq[i].len, WH);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    check("ld_sum", checksum, sum);
`else
    check("ld_sum", checksum, 0);
`endif
    check("stable", stable_bad, 0);
    check("modes", mode_bad, 0);
    exp_mode = 0;
  endtask

  task automatic do_rdbk(input logic [AW-1:0] base, input int cnt,
                         input int first_hold);
    int n, h, bad;
    logic [DW-1:0] d, sum;
    ren_q.delete();
    exp_mode = 3;
    issue(2'd3, 3'd0, base, AW'(cnt));
    check("to_clear", timeout, 0);
    sum = '0;
    bad = 0;
    for (int i = 0; i < cnt; i++) begin
      n = 0;
      while (!out_valid && n < 100) begin
        sync();
        n++;
      end
      if (n >= 100) check("out_wait", 0, 1);
      d = out_data;
      sum = sum + ref_dram[base + AW'(i)];
      check("rd_data", d, ref_dram[base + AW'(i)]);
      h = (i == 0) ? first_hold : $urandom_range(0, 3);
      repeat (h) begin
        sync();
        if (out_data !== d || !out_valid) bad++;
      end
      out_ready = 1'b1;
      sync();
      out_ready = 1'b0;
    end
    wait_idle();
    check("rd_hold", bad, 0);
    check("ren_cnt", ren_q.size(), cnt);
    foreach (ren_q[i]) check("ren_len", ren_q[i], RL);
`ifdef LOADER_CHECKSUM_EN
    check("rd_sum", checksum, sum);
`else
    check("rd_sum", checksum, 0);
`endif
    check("modes", mode_bad, 0);
    exp_mode = 0;
  endtask

  initial begin
    int e0, n;
    logic [1:0] op;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'($urandom);
      ref_dram[i] = mem[i];
    end
    sync();
    sync();
    check("rst_out", {cmd_ready, busy, err, timeout, start, in_ready,
                      out_valid, read_en_ext, dram_write_ext, iram_write_ext,
                      mode_ins, mode_dram, mode_read}, 0);
    check("rst_bus", {addr_ext, out_data, checksum}, 0);
    rst_n = 1'b1;
    check("rdy_early", cmd_ready, 0);
    sync();
    check("rdy_after", {cmd_ready, busy}, 2'b10);

    words = '{16'd10, 16'd20, 16'd30};
    do_load(2'd0, 3'd2, 9'd1);

    wq.delete();
    e0 = err_cycles;
    issue(2'd0, 3'd5, 9'd0, 9'd2);
    check("ill_err", {err, cmd_ready, busy}, 3'b110);
    sync();
    check("ill_pulse", err, 0);
    repeat (4) sync();
    check("ill_err_n", err_cycles - e0, 1);
    check("ill_wr", wq.size(), 0);

    words = '{DW'($urandom), DW'($urandom), DW'($urandom)};
    do_load(2'd1, 3'd0, 9'd510);

    wq.delete();
    issue(2'd1, 3'd0, 9'd7, 9'd0);
    check("z_idle", {busy, cmd_ready, in_ready}, 3'b010);
    issue(2'd3, 3'd0, 9'd7, 9'd0);
    check("z_rd", {busy, cmd_ready, out_valid}, 3'b010);
    repeat (4) sync();
    check("z_wr", wq.size(), 0);

    exp_mode = 4;
    start_len = 0;
    e0 = err_cycles;
    issue(2'd2, 3'd0, 9'd0, 9'd0);
    repeat (49) sync();
    proc_done = 1'b1;
    sync();
    proc_done = 1'b0;
    wait_idle();
    sync();
    check("run_len", start_len, 50);
    check("run_to", {timeout, 8'(err_cycles - e0)}, 0);

    start_len = 0;
    e0 = err_cycles;
    proc_done = 1'b1;
    issue(2'd2, 3'd0, 9'd0, 9'd0);
    proc_done = 1'b0;
    wait_idle();
    sync();
    check("to_len", start_len, RM);
    check("to_flag", timeout, 1);
    check("to_err", err_cycles - e0, 1);
    check("modes", mode_bad, 0);
    exp_mode = 0;

    mem[100] = 16'd7; ref_dram[100] = 16'd7;
    mem[101] = 16'd9; ref_dram[101] = 16'd9;
    do_rdbk(9'd100, 2, 10);
    do_rdbk(9'd510, 3, 2);

    exp_mode = 2;
    issue(2'd1, 3'd0, 9'd40, 9'd3);
    in_data = 16'h5a5a;
    in_valid = 1'b1;
    n = 0;
    while (!dram_write_ext && n < 50) begin
      sync();
      n++;
    end
    if (n >= 50) check("we_wait", 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_drop", {dram_write_ext, mode_dram, busy}, 0);
    in_valid = 1'b0;
    sync();
    sync();
    rst_n = 1'b1;
    exp_mode = 0;
    sync();
    check("rst_rec", {busy, cmd_ready}, 2'b01);
    wq.delete();
    words = '{DW'($urandom), DW'($urandom)};
    do_load(2'd1, 3'd0, 9'd40);
    do_rdbk(9'd40, 2, 1);

    for (int t = 0; t < 8; t++) begin
      op = 2'($urandom_range(0, 2));
      if (op == 2'd2) op = 2'd3;
      if (op == 2'd3) begin
        do_rdbk(AW'($urandom), $urandom_range(1, 4), $urandom_range(0, 5));
      end else begin
        words.delete();
        repeat ($urandom_range(1, 5)) words.push_back(DW'($urandom));
        do_load(op, 3'($urandom_range(0, NC - 1)), AW'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
